// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: access-size codes,
// byte-lane masks driven to ram_2, and the size-to-mask decode.
package ram_arb_pkg;

  localparam int RAM_W = 32;
  localparam int RAM_L = 4;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_THREEQ = 2'b10,
    SZ_WORD   = 2'b11
  } size_e;

  // Identifies a requester; also the encoding of the round-robin history.
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } port_e;

  localparam logic [3:0] BYTE        = 4'b0001;
  localparam logic [3:0] HALFWORD    = 4'b0011;
  localparam logic [3:0] THREEQUATER = 4'b0111;
  localparam logic [3:0] FULLWORD    = 4'b1111;

  // Contiguous low-lane mask for an access of the given size.
  function automatic logic [3:0] size_to_mask(input size_e size);
    logic [3:0] mask;
    case (size)
      SZ_BYTE:   mask = BYTE;
      SZ_HALF:   mask = HALFWORD;
      SZ_THREEQ: mask = THREEQUATER;
      default:   mask = FULLWORD;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the instruction-fetch port, the load/store port and the ram_2
// connection. The arbiter uses the slave view; requesters and the RAM
// model use the master view.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int W = RAM_W,
  parameter int L = RAM_L
) ();

  // Instruction fetch port
  logic         if_req_valid;
  logic         if_req_ready;
  logic [W-1:0] if_req_addr;
  logic         if_rsp_valid;
  logic         if_rsp_ready;
  logic [W-1:0] if_rsp_data;

  // Load/store port
  logic         ls_req_valid;
  logic         ls_req_ready;
  logic         ls_req_we;
  logic [1:0]   ls_req_size;
  logic         ls_req_sign;
  logic [W-1:0] ls_req_addr;
  logic [W-1:0] ls_req_wdat;
  logic         ls_rsp_valid;
  logic         ls_rsp_ready;
  logic [W-1:0] ls_rsp_data;

  // ram_2 connection
  logic [W-1:0] ram_addr;
  logic [W-1:0] ram_wdat;
  logic         ram_we;
  logic         ram_re;
  logic [L-1:0] ram_type;
  logic         sign;
  logic [W-1:0] data_reg;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  ls_req_valid, ls_req_we, ls_req_size, ls_req_sign,
    input  ls_req_addr, ls_req_wdat, ls_rsp_ready,
    input  data_reg,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output ram_addr, ram_wdat, ram_we, ram_re, ram_type, sign
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output ls_req_valid, ls_req_we, ls_req_size, ls_req_sign,
    output ls_req_addr, ls_req_wdat, ls_rsp_ready,
    output data_reg,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  ram_addr, ram_wdat, ram_we, ram_re, ram_type, sign
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the fetch port, bit 1 the
// load/store port. On a tie the port that did not win last time is granted.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  port_e r_last;

  // Grant decision: sole requester wins, a tie goes away from r_last.
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned,
    // which would infer a latch.
    o_gnt = 2'b00;
    if (i_req[0] && (!i_req[1] || r_last == GNT_LS)) begin
      o_gnt[0] = 1'b1;
    end else if (i_req[1]) begin
      o_gnt[1] = 1'b1;
    end
  end

  // History flop: reset to LS so the first tie after reset goes to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_last <= GNT_LS;
    end else if (o_gnt[0]) begin
      r_last <= GNT_IF;
    end else if (o_gnt[1]) begin
      r_last <= GNT_LS;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares ram_2 between instruction fetch and load/store: one access per
// cycle, RAM controls driven straight from the granted request, read data
// captured into a per-port response register with a valid/ready handshake.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int W = RAM_W,
  parameter int L = RAM_L
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   bus
);

  logic         r_if_rsp_valid;
  logic [W-1:0] r_if_rsp_data;
  logic         r_ls_rsp_valid;
  logic [W-1:0] r_ls_rsp_data;

  logic         w_if_elig;
  logic         w_ls_elig;
  logic [1:0]   w_gnt;
  logic [L-1:0] w_ls_mask;

  // A port may issue when its response slot is free or being drained now.
  // rst_n is folded in so nothing is granted (and no write reaches ram_2)
  // from the moment reset asserts, even mid-cycle.
  assign w_if_elig = rst_n & bus.if_req_valid & (~r_if_rsp_valid | bus.if_rsp_ready);
  assign w_ls_elig = rst_n & bus.ls_req_valid & (~r_ls_rsp_valid | bus.ls_rsp_ready);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({w_ls_elig, w_if_elig}),
    .o_gnt (w_gnt)
  );

  assign w_ls_mask        = size_to_mask(size_e'(bus.ls_req_size));
  assign bus.if_req_ready = w_gnt[0];
  assign bus.ls_req_ready = w_gnt[1];
  assign bus.if_rsp_valid = r_if_rsp_valid;
  assign bus.if_rsp_data  = r_if_rsp_data;
  assign bus.ls_rsp_valid = r_ls_rsp_valid;
  assign bus.ls_rsp_data  = r_ls_rsp_data;

  // RAM mux: idle drives all zeros, otherwise the granted request passes through.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_wdat = '0;
    bus.ram_we   = 1'b0;
    bus.ram_re   = 1'b0;
    bus.ram_type = '0;
    bus.sign     = 1'b0;
    if (w_gnt[0]) begin
      bus.ram_re   = 1'b1;
      bus.ram_type = FULLWORD;
      bus.ram_addr = bus.if_req_addr;
    end else if (w_gnt[1]) begin
      bus.ram_re   = ~bus.ls_req_we;
      bus.ram_we   = bus.ls_req_we;
      bus.ram_type = w_ls_mask;
      bus.sign     = bus.ls_req_sign;
      bus.ram_addr = bus.ls_req_addr;
      bus.ram_wdat = bus.ls_req_wdat;
    end
  end

  // Fetch response register: a grant reloads it even while it is being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
    end else if (w_gnt[0]) begin
      r_if_rsp_valid <= 1'b1;
      r_if_rsp_data  <= bus.data_reg;
    end else if (bus.if_rsp_ready) begin
      r_if_rsp_valid <= 1'b0;
    end
  end

  // Load/store response register: loads return read data, stores return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ls_rsp_valid <= 1'b0;
      r_ls_rsp_data  <= '0;
    end else if (w_gnt[1]) begin
      r_ls_rsp_valid <= 1'b1;
      r_ls_rsp_data  <= bus.ls_req_we ? '0 : bus.data_reg;
    end else if (bus.ls_rsp_ready) begin
      r_ls_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a byte-array ram_2 model on the RAM side, an
// independent reference memory plus per-port response state as the
// expectation model, directed scenarios with literal checks, then random traffic.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic clk;
  logic rst_n;

  ram_port_arbiter_if #(.W(32), .L(4)) bus ();

  ram_port_arbiter #(.W(32), .L(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ram_2 stand-in: byte array, combinational read, write at the rising edge.
  logic [7:0]  ram_mem [256];
  logic [31:0] env_rd;
  int          env_top;

  always_comb begin
    env_rd  = '0;
    env_top = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ram_type[i]) begin
        env_rd[8*i +: 8] = ram_mem[bus.ram_addr[7:0] + 8'(i)];
        env_top          = i;
      end
    end
    if (bus.sign && env_rd[8*env_top + 7]) begin
      for (int i = 0; i < 4; i++) begin
        if (i > env_top) env_rd[8*i +: 8] = 8'hFF;
      end
    end
  end
  assign bus.data_reg = env_rd;

  // Reference model state
  logic [7:0]  model_mem [256];
  bit          m_if_pend, m_ls_pend;
  logic [31:0] m_if_data, m_ls_data;
  bit          m_last_ls;

  // Write captured at the falling edge, applied to ram_mem at the rising edge
  bit          wr_pend;
  logic [7:0]  wr_addr;
  logic [3:0]  wr_type;
  logic [31:0] wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Load value from the reference memory: little-endian bytes, optional sign extension.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int nbytes, input bit sgn);
    longint v;
    v = 0;
    for (int i = 0; i < nbytes; i++)
      v += longint'(model_mem[addr[7:0] + 8'(i)]) << (8 * i);
    if (sgn && v >= (longint'(1) << (8 * nbytes - 1)))
      v -= longint'(1) << (8 * nbytes);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] addr, input int nbytes, input logic [31:0] wdat);
    for (int i = 0; i < nbytes; i++)
      model_mem[addr[7:0] + 8'(i)] = wdat[8*i +: 8];
  endtask

  // Per-cycle compare against the model, then advance the model by one edge.
  task automatic compare_cycle();
    bit e_if, e_ls, g_if, g_ls;
    int nb;
    wr_pend = bus.ram_we;
    wr_addr = bus.ram_addr[7:0];
    wr_type = bus.ram_type;
    wr_data = bus.ram_wdat;
    if (!rst_n) begin
      check("rst_if_req_ready", bus.if_req_ready, 0);
      check("rst_ls_req_ready", bus.ls_req_ready, 0);
      check("rst_if_rsp_valid", bus.if_rsp_valid, 0);
      check("rst_ls_rsp_valid", bus.ls_rsp_valid, 0);
      check("rst_if_rsp_data",  bus.if_rsp_data, 0);
      check("rst_ls_rsp_data",  bus.ls_rsp_data, 0);
      check("rst_ram_we",       bus.ram_we, 0);
      check("rst_ram_re",       bus.ram_re, 0);
      check("rst_ram_type",     bus.ram_type, 0);
      check("rst_ram_addr",     bus.ram_addr, 0);
      check("rst_ram_wdat",     bus.ram_wdat, 0);
      check("rst_sign",         bus.sign, 0);
      m_if_pend = 0;
      m_ls_pend = 0;
      m_if_data = '0;
      m_ls_data = '0;
      m_last_ls = 1;
      return;
    end
    check("if_rsp_valid", bus.if_rsp_valid, 32'(m_if_pend));
    check("ls_rsp_valid", bus.ls_rsp_valid, 32'(m_ls_pend));
    if (m_if_pend) check("if_rsp_data", bus.if_rsp_data, m_if_data);
    if (m_ls_pend) check("ls_rsp_data", bus.ls_rsp_data, m_ls_data);

    e_if = bus.if_req_valid && (!m_if_pend || bus.if_rsp_ready);
    e_ls = bus.ls_req_valid && (!m_ls_pend || bus.ls_rsp_ready);
    g_if = e_if && (!e_ls || m_last_ls);
    g_ls = e_ls && !g_if;
    nb   = int'(bus.ls_req_size) + 1;
    check("if_req_ready", bus.if_req_ready, 32'(g_if));
    check("ls_req_ready", bus.ls_req_ready, 32'(g_ls));

    if (g_if) begin
      check("if_ram_re",   bus.ram_re, 1);
      check("if_ram_we",   bus.ram_we, 0);
      check("if_ram_type", bus.ram_type, 32'hF);
      check("if_sign",     bus.sign, 0);
      check("if_ram_addr", bus.ram_addr, bus.if_req_addr);
    end else if (g_ls) begin
      check("ls_ram_re",   bus.ram_re, 32'(!bus.ls_req_we));
      check("ls_ram_we",   bus.ram_we, 32'(bus.ls_req_we));
      check("ls_ram_type", bus.ram_type, (32'd1 << nb) - 1);
      check("ls_sign",     bus.sign, 32'(bus.ls_req_sign));
      check("ls_ram_addr", bus.ram_addr, bus.ls_req_addr);
      check("ls_ram_wdat", bus.ram_wdat, bus.ls_req_wdat);
    end else begin
      check("idle_ram_ctl", {bus.ram_re, bus.ram_we, bus.sign, bus.ram_type}, 0);
      check("idle_ram_addr", bus.ram_addr, 0);
      check("idle_ram_wdat", bus.ram_wdat, 0);
    end

    if (m_if_pend && bus.if_rsp_ready) m_if_pend = 0;
    if (m_ls_pend && bus.ls_rsp_ready) m_ls_pend = 0;
    if (g_if) begin
      m_if_pend = 1;
      m_if_data = ref_load(bus.if_req_addr, 4, 0);
      m_last_ls = 0;
    end
    if (g_ls) begin
      m_ls_pend = 1;
      if (bus.ls_req_we) begin
        ref_store(bus.ls_req_addr, nb, bus.ls_req_wdat);
        m_ls_data = '0;
      end else begin
        m_ls_data = ref_load(bus.ls_req_addr, nb, bus.ls_req_sign);
      end
      m_last_ls = 1;
    end
  endtask

  // One clock: compare at the falling edge, commit any RAM write at the
  // rising edge, return 1 time unit later ready for the next drive.
  task automatic cycle();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    if (wr_pend) begin
      for (int i = 0; i < 4; i++)
        if (wr_type[i]) ram_mem[wr_addr + 8'(i)] = wr_data[8*i +: 8];
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid = 0;
    bus.if_req_addr  = '0;
    bus.ls_req_valid = 0;
    bus.ls_req_we    = 0;
    bus.ls_req_size  = 2'b00;
    bus.ls_req_sign  = 0;
    bus.ls_req_addr  = '0;
    bus.ls_req_wdat  = '0;
  endtask

  task automatic ls_drive(input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdat);
    bus.ls_req_valid = 1;
    bus.ls_req_we    = we;
    bus.ls_req_size  = size;
    bus.ls_req_sign  = sgn;
    bus.ls_req_addr  = addr;
    bus.ls_req_wdat  = wdat;
  endtask

  task automatic preset_byte(input logic [7:0] a, input logic [7:0] v);
    ram_mem[a]   = v;
    model_mem[a] = v;
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 0;
    idle_inputs();
    bus.if_rsp_ready = 0;
    bus.ls_rsp_ready = 0;
    wr_pend   = 0;
    m_if_pend = 0;
    m_ls_pend = 0;
    m_if_data = '0;
    m_ls_data = '0;
    m_last_ls = 1;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      preset_byte(8'(i), b);
    end
    preset_byte(8'h10, 8'h11); preset_byte(8'h11, 8'h22);
    preset_byte(8'h12, 8'h33); preset_byte(8'h13, 8'h44);
    preset_byte(8'h30, 8'hAA); preset_byte(8'h31, 8'hBB);
    preset_byte(8'h32, 8'hCC); preset_byte(8'h33, 8'hDD);
    preset_byte(8'h40, 8'h5A);

    // Held in reset with requests pending: nothing may be granted.
    @(posedge clk); #1;
    bus.if_req_valid = 1;
    bus.if_req_addr  = 32'h10;
    cycle();
    cycle();
    check("reset_no_grant", bus.if_req_ready, 0);
    idle_inputs();
    rst_n = 1;

    // Fetch of 0x10
    bus.if_rsp_ready = 1;
    bus.ls_rsp_ready = 1;
    bus.if_req_valid = 1;
    bus.if_req_addr  = 32'h10;
    #1;
    check("t1_ready",    bus.if_req_ready, 1);
    check("t1_ram_re",   bus.ram_re, 1);
    check("t1_ram_type", bus.ram_type, 32'hF);
    cycle();
    bus.if_req_valid = 0;
    #1;
    check("t1_rsp_valid", bus.if_rsp_valid, 1);
    check("t1_rsp_data",  bus.if_rsp_data, 32'h44332211);
    cycle();

    // Word store, then signed and unsigned byte loads of the same address
    ls_drive(1, 2'b11, 0, 32'h20, 32'hDEADBEEF);
    cycle();
    ls_drive(0, 2'b00, 1, 32'h20, 32'h0);
    #1;
    check("t2_store_ack", bus.ls_rsp_data, 0);
    cycle();
    ls_drive(0, 2'b00, 0, 32'h20, 32'h0);
    #1;
    check("t2_lb_signed", bus.ls_rsp_data, 32'hFFFFFFEF);
    cycle();
    idle_inputs();
    #1;
    check("t2_lb_unsigned", bus.ls_rsp_data, 32'h000000EF);
    cycle();

    // Both ports requesting every cycle: strict alternation starting with fetch
    for (int k = 0; k < 6; k++) begin
      bus.if_req_valid = 1;
      bus.if_req_addr  = 32'($urandom_range(0, 255));
      ls_drive(0, 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)), 32'h0);
      #1;
      check("t3_if_grant", bus.if_req_ready, 32'(k % 2 == 0));
      check("t3_ls_grant", bus.ls_req_ready, 32'(k % 2 == 1));
      cycle();
    end

    // LS response stalled: fetch keeps winning, then pop and regrant together
    bus.if_req_valid = 0;
    ls_drive(0, 2'b11, 0, 32'h10, 32'h0);
    cycle();
    bus.ls_rsp_ready = 0;
    bus.if_req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      bus.if_req_addr = 32'($urandom_range(0, 255));
      #1;
      check("t4_ls_blocked", bus.ls_req_ready, 0);
      check("t4_if_granted", bus.if_req_ready, 1);
      check("t4_ls_pending", bus.ls_rsp_valid, 1);
      cycle();
    end
    bus.ls_rsp_ready = 1;
    #1;
    check("t4_ls_regrant", bus.ls_req_ready, 1);
    check("t4_if_waits",   bus.if_req_ready, 0);
    cycle();
    idle_inputs();
    cycle();

    // Half-word store straddling 0x31/0x32
    ls_drive(1, 2'b01, 0, 32'h31, 32'h00001234);
    #1;
    check("t5_ram_type", bus.ram_type, 32'h3);
    check("t5_ram_we",   bus.ram_we, 1);
    cycle();
    idle_inputs();
    check("t5_b30", ram_mem[8'h30], 32'hAA);
    check("t5_b31", ram_mem[8'h31], 32'h34);
    check("t5_b32", ram_mem[8'h32], 32'h12);
    check("t5_b33", ram_mem[8'h33], 32'hDD);
    cycle();

    // Reset dropped in the middle of a store grant
    ls_drive(1, 2'b00, 0, 32'h40, 32'h000000A5);
    #1;
    check("t6_we_before", bus.ram_we, 1);
    rst_n = 0;
    #1;
    check("t6_we_cut",    bus.ram_we, 0);
    check("t6_no_grant",  bus.ls_req_ready, 0);
    cycle();
    check("t6_byte_kept", ram_mem[8'h40], 32'h5A);
    check("t6_rsp_empty", bus.ls_rsp_valid, 0);
    idle_inputs();
    rst_n = 1;
    cycle();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      bus.if_req_valid = ($urandom_range(0, 3) != 0);
      bus.if_req_addr  = $urandom;
      bus.if_rsp_ready = ($urandom_range(0, 3) != 0);
      bus.ls_rsp_ready = ($urandom_range(0, 3) != 0);
      ls_drive(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      bus.ls_req_valid = ($urandom_range(0, 2) != 0);
      cycle();
    end

    idle_inputs();
    bus.if_rsp_ready = 1;
    bus.ls_rsp_ready = 1;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
